// File: rtl/cronometro_bcd_mmss.sv
// MM:SS.CC BCD stopwatch/countdown with preset load, wrap/saturate, terminal flag and lap freeze.
// Live and lap values are packed {m_dez, m_uni, s_dez, s_uni, cs_dez, cs_uni}.
`timescale 1ns/1ps
module cronometro_bcd_mmss #(
  parameter int MAX_MIN_DEZ = 5,
  parameter int MAX_MIN_UNI = 9,
  parameter bit WRAP        = 1'b1
) (
  input  logic       clk_100hz,
  input  logic       reset,
  input  logic       enable,
  input  logic       modo,
  input  logic       load,
  input  logic [3:0] m_dezena_in,
  input  logic [3:0] m_unidade_in,
  input  logic [3:0] s_dezena_in,
  input  logic [3:0] s_unidade_in,
  input  logic       lap,
  output logic [3:0] cs_unidade,
  output logic [3:0] cs_dezena,
  output logic [3:0] s_unidade,
  output logic [3:0] s_dezena,
  output logic [3:0] m_unidade,
  output logic [3:0] m_dezena,
  output logic       lap_ativo,
  output logic       fim,
  output logic       wrap,
  output logic       erro
);

  localparam logic [3:0] MAX_DEZ = MAX_MIN_DEZ[3:0];
  localparam logic [3:0] MAX_UNI = MAX_MIN_UNI[3:0];
  localparam logic [23:0] MAX_VAL = {MAX_DEZ, MAX_UNI, 4'd5, 4'd9, 4'd9, 4'd9};

  logic [23:0] live, lap_q, up_val, dn_val, shown;
  logic        load_ok, at_max, at_zero, at_one;

  assign load_ok = (m_dezena_in <= 4'd9) && (m_unidade_in <= 4'd9) &&
                   (s_dezena_in <= 4'd5) && (s_unidade_in <= 4'd9) &&
                   ((m_dezena_in < MAX_DEZ) ||
                    ((m_dezena_in == MAX_DEZ) && (m_unidade_in <= MAX_UNI)));

  assign at_max  = (live == MAX_VAL);
  assign at_zero = (live == 24'h000000);
  assign at_one  = (live == 24'h000001);

  // Ripple increment, one BCD digit at a time; the maximum is handled separately.
  always_comb begin
    up_val = live;
    if (live[3:0] != 4'd9) up_val[3:0] = live[3:0] + 4'd1;
    else begin
      up_val[3:0] = 4'd0;
      if (live[7:4] != 4'd9) up_val[7:4] = live[7:4] + 4'd1;
      else begin
        up_val[7:4] = 4'd0;
        if (live[11:8] != 4'd9) up_val[11:8] = live[11:8] + 4'd1;
        else begin
          up_val[11:8] = 4'd0;
          if (live[15:12] != 4'd5) up_val[15:12] = live[15:12] + 4'd1;
          else begin
            up_val[15:12] = 4'd0;
            if (live[19:16] != 4'd9) up_val[19:16] = live[19:16] + 4'd1;
            else begin
              up_val[19:16] = 4'd0;
              up_val[23:20] = live[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    dn_val = live;
    if (live[3:0] != 4'd0) dn_val[3:0] = live[3:0] - 4'd1;
    else begin
      dn_val[3:0] = 4'd9;
      if (live[7:4] != 4'd0) dn_val[7:4] = live[7:4] - 4'd1;
      else begin
        dn_val[7:4] = 4'd9;
        if (live[11:8] != 4'd0) dn_val[11:8] = live[11:8] - 4'd1;
        else begin
          dn_val[11:8] = 4'd9;
          if (live[15:12] != 4'd0) dn_val[15:12] = live[15:12] - 4'd1;
          else begin
            dn_val[15:12] = 4'd5;
            if (live[19:16] != 4'd0) dn_val[19:16] = live[19:16] - 4'd1;
            else begin
              dn_val[19:16] = 4'd9;
              dn_val[23:20] = live[23:20] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_100hz) begin
    if (reset) begin
      live      <= '0;
      lap_q     <= '0;
      lap_ativo <= 1'b0;
      fim       <= 1'b0;
      wrap      <= 1'b0;
      erro      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      erro <= 1'b0;
      // Lap snapshots the pre-update live value and runs independently of load/count.
      if (lap) begin
        if (!lap_ativo) lap_q <= live;
        lap_ativo <= ~lap_ativo;
      end
      if (load) begin
        if (load_ok) begin
          live <= {m_dezena_in, m_unidade_in, s_dezena_in, s_unidade_in, 8'h00};
          fim  <= 1'b0;
        end else begin
          erro <= 1'b1;
        end
      end else if (enable) begin
        if (!modo) begin
          if (at_max) begin
            if (WRAP) begin
              live <= '0;
              wrap <= 1'b1;
              fim  <= 1'b0;
            end else begin
              fim <= 1'b1;
            end
          end else begin
            live <= up_val;
            fim  <= 1'b0;
          end
        end else begin
          if (at_zero) fim <= 1'b1;
          else begin
            live <= dn_val;
            if (at_one) fim <= 1'b1;
          end
        end
      end
    end
  end

  assign shown      = lap_ativo ? lap_q : live;
  assign cs_unidade = shown[3:0];
  assign cs_dezena  = shown[7:4];
  assign s_unidade  = shown[11:8];
  assign s_dezena   = shown[15:12];
  assign m_unidade  = shown[19:16];
  assign m_dezena   = shown[23:20];

endmodule

// File: tb/tb_cronometro_bcd_mmss.sv
// Bench for cronometro_bcd_mmss: two instances (wrap and saturate) against a centisecond-integer model.
`timescale 1ns/1ps
module tb_cronometro_bcd_mmss;

  localparam int MAX_MIN = 59;
  localparam int MAX_T   = (MAX_MIN * 60 + 59) * 100 + 99;

  logic clk_100hz = 1'b0;
  logic reset = 1'b1, enable = 1'b0, modo = 1'b0, load = 1'b0, lap = 1'b0;
  logic [3:0] m_dezena_in = '0, m_unidade_in = '0, s_dezena_in = '0, s_unidade_in = '0;

  logic [3:0] cs_u_a, cs_d_a, s_u_a, s_d_a, m_u_a, m_d_a;
  logic [3:0] cs_u_b, cs_d_b, s_u_b, s_d_b, m_u_b, m_d_b;
  logic lap_a, fim_a, wrap_a, erro_a, lap_b, fim_b, wrap_b, erro_b;
  logic [27:0] obs_a, obs_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit wrap_seen;

  always #5 clk_100hz = ~clk_100hz;

  cronometro_bcd_mmss #(.MAX_MIN_DEZ(5), .MAX_MIN_UNI(9), .WRAP(1'b1)) dut_a (
    .clk_100hz(clk_100hz), .reset(reset), .enable(enable), .modo(modo), .load(load),
    .m_dezena_in(m_dezena_in), .m_unidade_in(m_unidade_in),
    .s_dezena_in(s_dezena_in), .s_unidade_in(s_unidade_in), .lap(lap),
    .cs_unidade(cs_u_a), .cs_dezena(cs_d_a), .s_unidade(s_u_a), .s_dezena(s_d_a),
    .m_unidade(m_u_a), .m_dezena(m_d_a),
    .lap_ativo(lap_a), .fim(fim_a), .wrap(wrap_a), .erro(erro_a));

  cronometro_bcd_mmss #(.MAX_MIN_DEZ(5), .MAX_MIN_UNI(9), .WRAP(1'b0)) dut_b (
    .clk_100hz(clk_100hz), .reset(reset), .enable(enable), .modo(modo), .load(load),
    .m_dezena_in(m_dezena_in), .m_unidade_in(m_unidade_in),
    .s_dezena_in(s_dezena_in), .s_unidade_in(s_unidade_in), .lap(lap),
    .cs_unidade(cs_u_b), .cs_dezena(cs_d_b), .s_unidade(s_u_b), .s_dezena(s_d_b),
    .m_unidade(m_u_b), .m_dezena(m_d_b),
    .lap_ativo(lap_b), .fim(fim_b), .wrap(wrap_b), .erro(erro_b));

  assign obs_a = {m_d_a, m_u_a, s_d_a, s_u_a, cs_d_a, cs_u_a, lap_a, fim_a, wrap_a, erro_a};
  assign obs_b = {m_d_b, m_u_b, s_d_b, s_u_b, cs_d_b, cs_u_b, lap_b, fim_b, wrap_b, erro_b};

  // Reference: the time is one integer of centiseconds.
  typedef struct {
    int live;
    int lap_val;
    bit lap_ativo;
    bit fim;
    bit wrap;
    bit erro;
  } mst_t;

  mst_t m_a, m_b;

  function automatic mst_t model_step(mst_t s, bit wrap_en);
    mst_t n;
    int mins;
    bit ok;
    n = s;
    n.wrap = 1'b0;
    n.erro = 1'b0;
    if (reset) begin
      n.live = 0; n.lap_val = 0; n.lap_ativo = 0; n.fim = 0;
      return n;
    end
    if (lap) begin
      if (!s.lap_ativo) begin
        n.lap_val = s.live;
        n.lap_ativo = 1'b1;
      end else begin
        n.lap_ativo = 1'b0;
      end
    end
    if (load) begin
      mins = int'(m_dezena_in) * 10 + int'(m_unidade_in);
      ok = (m_dezena_in <= 9) && (m_unidade_in <= 9) && (s_dezena_in <= 5) &&
           (s_unidade_in <= 9) && (mins <= MAX_MIN);
      if (ok) begin
        n.live = mins * 6000 + (int'(s_dezena_in) * 10 + int'(s_unidade_in)) * 100;
        n.fim = 1'b0;
      end else begin
        n.erro = 1'b1;
      end
    end else if (enable) begin
      if (!modo) begin
        if (s.live == MAX_T) begin
          if (wrap_en) begin n.live = 0; n.wrap = 1'b1; n.fim = 1'b0; end
          else n.fim = 1'b1;
        end else begin
          n.live = s.live + 1;
          n.fim = 1'b0;
        end
      end else begin
        if (s.live == 0) n.fim = 1'b1;
        else begin
          n.live = s.live - 1;
          if (n.live == 0) n.fim = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [27:0] exp_vec(mst_t s);
    int v, mm, ss, cc;
    v  = s.lap_ativo ? s.lap_val : s.live;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10),
            s.lap_ativo, s.fim, s.wrap, s.erro};
  endfunction

  task automatic check(input string tag, input logic [27:0] observed, input logic [27:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_100hz);
    m_a = model_step(m_a, 1'b1);
    m_b = model_step(m_b, 1'b0);
    #1;
    cyc++;
    if (wrap_a === 1'b1) wrap_seen = 1'b1;
    check("model_wrap", obs_a, exp_vec(m_a));
    check("model_sat", obs_b, exp_vec(m_b));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preset(input logic [3:0] md, input logic [3:0] mu,
                        input logic [3:0] sd, input logic [3:0] su);
    m_dezena_in = md; m_unidade_in = mu; s_dezena_in = sd; s_unidade_in = su;
  endtask

  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};

    // Reset
    reset = 1'b1;
    run(2);
    check("reset_a", obs_a, 28'h0);
    check("reset_b", obs_b, 28'h0);
    reset = 1'b0;

    // One minute of counting up
    wrap_seen = 1'b0;
    enable = 1'b1; modo = 1'b0;
    run(6000);
    check("up_6000_digits", {4'h0, obs_a[27:4]}, 28'h0010000);
    check("up_6000_fim", {27'h0, obs_a[2]}, 28'h0);
    check("up_6000_nowrap", {27'h0, wrap_seen}, 28'h0);

    // Maximum: wrap vs saturate
    preset(4'd5, 4'd9, 4'd5, 4'd9); load = 1'b1;
    run(1);
    load = 1'b0;
    run(99);
    check("max_a", {4'h0, obs_a[27:4]}, 28'h0595999);
    check("max_b", {4'h0, obs_b[27:4]}, 28'h0595999);
    run(1);
    check("rollover_digits", {4'h0, obs_a[27:4]}, 28'h0000000);
    check("rollover_wrap", {27'h0, obs_a[1]}, 28'h1);
    check("sat_hold", {4'h0, obs_b[27:4]}, 28'h0595999);
    check("sat_fim", {27'h0, obs_b[2]}, 28'h1);
    run(1);
    check("wrap_one_cycle", {27'h0, obs_a[1]}, 28'h0);

    // Countdown from 01:00
    preset(4'd0, 4'd1, 4'd0, 4'd0); load = 1'b1; modo = 1'b1;
    run(1);
    load = 1'b0;
    run(1);
    check("down_borrow", {4'h0, obs_a[27:4]}, 28'h0005999);
    run(5999);
    check("down_zero", {4'h0, obs_a[27:4]}, 28'h0000000);
    check("down_fim", {27'h0, obs_b[2]}, 28'h1);
    run(3);
    check("down_hold", {4'h0, obs_b[27:4]}, 28'h0000000);

    // Preset validation
    enable = 1'b0;
    preset(4'd0, 4'd6, 4'd7, 4'd0); load = 1'b1;
    run(1);
    check("bad_sdez_erro", {27'h0, obs_a[0]}, 28'h1);
    check("bad_sdez_live", {4'h0, obs_a[27:4]}, 28'h0000000);
    preset(4'd6, 4'd0, 4'd0, 4'd0);
    run(1);
    check("bad_min_erro", {27'h0, obs_b[0]}, 28'h1);
    preset(4'd1, 4'd2, 4'd3, 4'd4);
    run(1);
    check("good_load", {4'h0, obs_a[27:4]}, 28'h0123400);
    check("good_load_flags", {24'h0, obs_a[3:0]}, 28'h0);
    load = 1'b0;

    // Lap freeze
    preset(4'd0, 4'd0, 4'd0, 4'd3); load = 1'b1; enable = 1'b1; modo = 1'b0;
    run(1);
    load = 1'b0;
    run(21);
    check("lap_pre", {4'h0, obs_a[27:4]}, 28'h0000321);
    lap = 1'b1;
    run(1);
    lap = 1'b0;
    check("lap_frozen", obs_a[27:3], 25'({24'h000321, 1'b1}));
    run(99);
    check("lap_still", {4'h0, obs_a[27:4]}, 28'h0000321);
    enable = 1'b0; lap = 1'b1;
    run(1);
    lap = 1'b0;
    check("lap_release", obs_a[27:3], 25'({24'h000421, 1'b0}));

    // Reset beats load and lap
    preset(4'd0, 4'd0, 4'd2, 4'd7); load = 1'b1; enable = 1'b1;
    run(1);
    load = 1'b0;
    run(53);
    check("pre_reset", {4'h0, obs_a[27:4]}, 28'h0002753);
    reset = 1'b1; load = 1'b1; lap = 1'b1;
    run(1);
    check("reset_prio_a", obs_a, 28'h0);
    check("reset_prio_b", obs_b, 28'h0);
    reset = 1'b0; load = 1'b0; lap = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      load   = ($urandom_range(0, 24) == 0);
      lap    = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) modo = ~modo;
      if (load) begin
        case ($urandom_range(0, 9))
          0, 1: preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
          2, 3: preset(4'd0, 4'd0, 4'd0, 4'($urandom_range(0, 1)));
          4:    preset(4'd5, 4'd9, 4'd5, 4'd9);
          default: preset(4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
        endcase
      end
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cronometro_bcd_mmss.md
Name: cronometro_bcd_mmss

Overview:
- Parametrised successor of the seconds/centiseconds stopwatch counter.
- Counts MM:SS.CC in BCD: minutes, seconds (0-59) and centiseconds (0-99). Counting is up or down (countdown timer).
- Adds a synchronous preset load, wrap/saturate policy, terminal flag and lap-freeze display.
- Sits between the 100 Hz clock divider and the 7-segment decoders. Drives HEX0-HEX5.

Parameters:
- MAX_MIN_DEZ, 5, tens digit of the maximum minute value (0-9).
- MAX_MIN_UNI, 9, units digit of the maximum minute value (0-9). Maximum minutes = MAX_MIN_DEZ*10 + MAX_MIN_UNI.
- WRAP, 1, up mode at maximum: 1 = roll over to 00:00.00; 0 = hold at maximum and set fim.

Ports:
- clk_100hz  in  1  100 Hz clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  one count step per clock while high.
- modo  in  1  0 = count up, 1 = count down.
- load  in  1  preset strobe.
- m_dezena_in, m_unidade_in, s_dezena_in, s_unidade_in  in  4 each  BCD preset (centiseconds preset to 00).
- lap  in  1  single-cycle pulse; toggles display freeze.
- cs_unidade, cs_dezena, s_unidade, s_dezena, m_unidade, m_dezena  out  4 each  displayed BCD digits (HEX0..HEX5).
- lap_ativo  out  1  display frozen.
- fim  out  1  sticky terminal flag.
- wrap  out  1  one-cycle pulse on an up-mode rollover.
- erro  out  1  one-cycle pulse on a rejected load.

Behaviour:
- All state is registered on the rising edge of clk_100hz.
- Displayed digits are combinational: lap registers when lap_ativo=1, otherwise the live counter.

Reset:
- Reset has priority over everything.
- Live counter, lap registers, lap_ativo, fim, wrap and erro all go to 0.

Load (priority below reset, above counting):
- A preset is valid when every digit is 9 or less, s_dezena_in is 5 or less, and minutes are at most the maximum.
- Valid preset: live becomes MM:SS.00 and fim clears. No count step occurs that cycle.
- Invalid preset: live is unchanged and erro=1 for one cycle.

Count up (enable=1, modo=0, load=0):
- Centiseconds count 0-99. On 99 they go to 0 and carry into seconds.
- Seconds count 0-59. On 59 they go to 0 and carry into minutes.
- Minutes count 0 to the maximum.
- At maximum:59.99:
  - WRAP=1: next value 00:00.00, wrap=1 for that cycle.
  - WRAP=0: hold, fim=1.
- fim clears on any up step that changes the value.

Count down (enable=1, modo=1, load=0):
- Borrows mirror the up mode: CC 00 becomes 99 with a borrow from seconds; SS 00 becomes 59 with a borrow from minutes.
- At 00:00.00 the counter holds and fim=1. There is never a down-mode wrap.
- Reaching 00:00.00 from 00:00.01 sets fim in the same cycle the value becomes zero.

Other counting rules:
- enable=0: live holds, flags hold, wrap=0.
- modo changes take effect on the next step with no extra latency. Switching to up while fim=1 clears fim on the first changing step.

Lap (independent of load and count):
- lap=1 with lap_ativo=0: lap registers capture the live value present before this cycle's update; lap_ativo becomes 1.
- lap=1 with lap_ativo=1: lap_ativo becomes 0 and the display shows live.
- The live counter continues throughout.
- Load while frozen does not alter the lap registers.

Digit invariants:
- Digits never leave BCD range.
- All arithmetic is per-digit, 4 bits, no binary intermediate.

Test Plan:
- Reset, then enable=1, modo=0 for 6000 clocks -> live 01:00.00; fim=0; wrap never asserted.
- Load 59:59, then up 99 clocks -> 59:59.99; next clock with WRAP=1 -> 00:00.00 and wrap=1 for exactly one cycle. Same sequence with WRAP=0 -> holds at 59:59.99, fim=1.
- Load 01:00, modo=1, one clock -> 00:59.99. Continue 5999 clocks -> 00:00.00 with fim=1; further clocks hold zero.
- Load 06:70 -> erro pulse, live unchanged. Load with m_dezena_in=6 at default parameters -> erro. Load 12:34 -> 12:34.00, fim cleared.
- Count to 00:03.21, pulse lap -> display stays 00:03.21 while live advances. After 100 clocks pulse lap -> display 00:04.21 (live), lap_ativo=0.
- Reset asserted mid-count at 00:27.53 together with load and lap -> all outputs 0 on the next edge; load and lap ignored.
